// File: rtl/astra_if.sv
// Board-side pin bundle for astra: RS-485 UART0, two 8-bit parallel DACs, static control lines.
// The master modport is the astra side; slave is the board/harness side.
interface astra_if;
  logic UART0_RX;
  logic UART0_TX;
  logic UART0_dTX;
  logic UART0_dRX;
  logic DAC_MODE;
  logic SKUT_MBR;
  logic SKUT_VI;
  logic DAC1_CLK;
  logic DAC1_DB0, DAC1_DB1, DAC1_DB2, DAC1_DB3;
  logic DAC1_DB4, DAC1_DB5, DAC1_DB6, DAC1_DB7;
  logic DAC2_CLK;
  logic DAC2_DB0, DAC2_DB1, DAC2_DB2, DAC2_DB3;
  logic DAC2_DB4, DAC2_DB5, DAC2_DB6, DAC2_DB7;

  modport master (
    input  UART0_RX,
    output UART0_TX, UART0_dTX, UART0_dRX,
    output DAC_MODE, SKUT_MBR, SKUT_VI,
    output DAC1_CLK, DAC1_DB0, DAC1_DB1, DAC1_DB2, DAC1_DB3,
    output DAC1_DB4, DAC1_DB5, DAC1_DB6, DAC1_DB7,
    output DAC2_CLK, DAC2_DB0, DAC2_DB1, DAC2_DB2, DAC2_DB3,
    output DAC2_DB4, DAC2_DB5, DAC2_DB6, DAC2_DB7
  );

  modport slave (
    output UART0_RX,
    input  UART0_TX, UART0_dTX, UART0_dRX,
    input  DAC_MODE, SKUT_MBR, SKUT_VI,
    input  DAC1_CLK, DAC1_DB0, DAC1_DB1, DAC1_DB2, DAC1_DB3,
    input  DAC1_DB4, DAC1_DB5, DAC1_DB6, DAC1_DB7,
    input  DAC2_CLK, DAC2_DB0, DAC2_DB1, DAC2_DB2, DAC2_DB3,
    input  DAC2_DB4, DAC2_DB5, DAC2_DB6, DAC2_DB7
  );
endinterface

// File: rtl/astra.sv
// A-03 telemetry/stimulus top: UART0 2-byte command parser with ack, sawtooth DAC1, level DAC2.
// Define ASTRA_DAC2_MIRROR_EN to drive DAC2 with 255 - DAC1 instead of level2.
module astra #(
  parameter int unsigned BAUD_DIV     = 700,
  parameter int unsigned DAC_DIV      = 16,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic    clk80,
  input  logic    rst_n,
  astra_if.master pins
);

  localparam int unsigned BaudW      = $clog2(BAUD_DIV);
  localparam int unsigned DivW       = $clog2(DAC_DIV);
  localparam int unsigned ToutCycles = TIMEOUT_BITS * BAUD_DIV;
  localparam int unsigned ToutW      = $clog2(ToutCycles);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_DIV - 1);
  localparam logic [BaudW-1:0] BaudMid  = BaudW'(BAUD_DIV / 2 - 1);
  localparam logic [DivW-1:0]  DivLast  = DivW'(DAC_DIV - 1);
  localparam logic [DivW-1:0]  DivHalf  = DivW'(DAC_DIV / 2);
  localparam logic [ToutW-1:0] ToutLast = ToutW'(ToutCycles - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic {PsAddr, PsValue} ps_state_e;
  typedef enum logic [2:0] {TxIdle, TxLead, TxStart, TxData, TxStop, TxTrail} tx_state_e;

  // Configuration registers
  logic [7:0] step1_q, level2_q;
  logic [2:0] ctrl_q;

  // DAC timing and data
  logic [DivW-1:0] div_q, div_d;
  logic            dac_clk_q;
  logic [7:0]      ramp_q, ramp_next, dac2_q;

  // UART receiver
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e        rx_st_q, rx_st_d;
  logic [BaudW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_valid, rx_ferr;

  // Command parser
  ps_state_e        ps_st_q, ps_st_d;
  logic [7:0]       addr_q, addr_d;
  logic [ToutW-1:0] tout_q, tout_d;
  logic             addr_ok, wr_en, ack_v;
  logic [7:0]       ack_data;

  // UART transmitter
  tx_state_e        tx_st_q, tx_st_d;
  logic [BaudW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             pend_q, pend_d;
  logic [7:0]       pend_data_q, pend_data_d;
  logic             tx_load;
  logic             tx_line_q, tx_line_d;
  logic             tx_en_q, tx_en_d;

  // ---------------------------------------------------------------------------
  // DAC sample generator
  // ---------------------------------------------------------------------------
  assign div_d     = (div_q == DivLast) ? '0 : div_q + DivW'(1);
  assign ramp_next = ramp_q + step1_q;

  always_ff @(posedge clk80 or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      dac_clk_q <= 1'b0;
      ramp_q    <= 8'h00;
      dac2_q    <= 8'h00;
    end else begin
      div_q     <= div_d;
      // Registered copy of (div >= DAC_DIV/2) so the DAC latch clocks are glitch-free.
      dac_clk_q <= (div_d >= DivHalf);
      if (div_q == '0) begin
        ramp_q <= ramp_next;
`ifdef ASTRA_DAC2_MIRROR_EN
        dac2_q <= ~ramp_next;
`else
        dac2_q <= level2_q;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // UART receiver, 8N1, LSB first
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk80 or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= 8'h00;
    end else begin
      rx_meta_q  <= pins.UART0_RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q + BaudW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid   = 1'b0;
    rx_ferr    = 1'b0;
    if (tx_en_q) begin
      // Half-duplex bus: our own transmission must not be parsed as a command.
      rx_st_d  = RxIdle;
      rx_cnt_d = '0;
    end else begin
      unique case (rx_st_q)
        RxIdle: begin
          rx_cnt_d = '0;
          if (rx_prev_q && !rx_sync_q) rx_st_d = RxStart;
        end
        RxStart: begin
          if (rx_cnt_q == BaudMid) begin
            rx_cnt_d = '0;
            rx_bit_d = '0;
            rx_st_d  = rx_sync_q ? RxIdle : RxData;
          end
        end
        RxData: begin
          if (rx_cnt_q == BaudLast) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_d = RxStop;
          end
        end
        RxStop: begin
          if (rx_cnt_q == BaudLast) begin
            rx_cnt_d = '0;
            rx_st_d  = RxIdle;
            rx_valid = rx_sync_q;
            rx_ferr  = !rx_sync_q;
          end
        end
        default: rx_st_d = RxIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Address/value parser and register file
  // ---------------------------------------------------------------------------
  assign addr_ok = (addr_q == 8'h01) || (addr_q == 8'h02) || (addr_q == 8'h03);

  always_comb begin
    ps_st_d  = ps_st_q;
    addr_d   = addr_q;
    tout_d   = '0;
    wr_en    = 1'b0;
    ack_v    = 1'b0;
    ack_data = 8'hFF;
    unique case (ps_st_q)
      PsAddr: begin
        if (rx_valid) begin
          addr_d  = rx_shift_q;
          ps_st_d = PsValue;
        end
      end
      PsValue: begin
        tout_d = tout_q + ToutW'(1);
        if (rx_valid) begin
          ps_st_d  = PsAddr;
          ack_v    = 1'b1;
          wr_en    = addr_ok;
          ack_data = addr_ok ? rx_shift_q : 8'hFF;
        end else if (rx_ferr || (tout_q == ToutLast)) begin
          ps_st_d = PsAddr;
        end
      end
      default: ps_st_d = PsAddr;
    endcase
  end

  always_ff @(posedge clk80 or negedge rst_n) begin
    if (!rst_n) begin
      ps_st_q  <= PsAddr;
      addr_q   <= 8'h00;
      tout_q   <= '0;
      step1_q  <= 8'h01;
      level2_q <= 8'h80;
      ctrl_q   <= 3'b000;
    end else begin
      ps_st_q <= ps_st_d;
      addr_q  <= addr_d;
      tout_q  <= tout_d;
      if (wr_en) begin
        case (addr_q)
          8'h01:   step1_q  <= rx_shift_q;
          8'h02:   level2_q <= rx_shift_q;
          8'h03:   ctrl_q   <= rx_shift_q[2:0];
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Ack transmitter with a single pending slot
  // ---------------------------------------------------------------------------
  assign tx_load = (tx_st_q == TxIdle) && (pend_q || ack_v);

  always_comb begin
    tx_st_d     = tx_st_q;
    tx_cnt_d    = tx_cnt_q + BaudW'(1);
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;

    if (tx_load && pend_q) begin
      pend_d = ack_v;
      if (ack_v) pend_data_d = ack_data;
    end else if (ack_v && !tx_load && !pend_q) begin
      pend_d      = 1'b1;
      pend_data_d = ack_data;
    end

    unique case (tx_st_q)
      TxIdle: begin
        tx_cnt_d = '0;
        if (tx_load) begin
          tx_st_d    = TxLead;
          tx_shift_d = pend_q ? pend_data_q : ack_data;
        end
      end
      TxLead: begin
        tx_cnt_d = '0;
        tx_st_d  = TxStart;
      end
      TxStart: begin
        if (tx_cnt_q == BaudLast) begin
          tx_cnt_d = '0;
          tx_bit_d = '0;
          tx_st_d  = TxData;
        end
      end
      TxData: begin
        if (tx_cnt_q == BaudLast) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b1, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_st_d = TxStop;
        end
      end
      TxStop: begin
        if (tx_cnt_q == BaudLast) begin
          tx_cnt_d = '0;
          tx_st_d  = TxTrail;
        end
      end
      TxTrail: begin
        tx_cnt_d = '0;
        tx_st_d  = TxIdle;
      end
      default: tx_st_d = TxIdle;
    endcase

    // Line and driver enable are decoded from the current state, then registered together.
    tx_en_d = (tx_st_q != TxIdle);
    unique case (tx_st_q)
      TxStart: tx_line_d = 1'b0;
      TxData:  tx_line_d = tx_shift_q[0];
      default: tx_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk80 or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q     <= TxIdle;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= 8'h00;
      pend_q      <= 1'b0;
      pend_data_q <= 8'h00;
      tx_line_q   <= 1'b1;
      tx_en_q     <= 1'b0;
    end else begin
      tx_st_q     <= tx_st_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      tx_line_q   <= tx_line_d;
      tx_en_q     <= tx_en_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pin mapping
  // ---------------------------------------------------------------------------
  assign pins.UART0_TX  = tx_line_q;
  assign pins.UART0_dTX = tx_en_q;
  assign pins.UART0_dRX = tx_en_q;
  assign pins.DAC_MODE  = ctrl_q[0];
  assign pins.SKUT_MBR  = ctrl_q[1];
  assign pins.SKUT_VI   = ctrl_q[2];

  assign pins.DAC1_CLK = dac_clk_q;
  assign pins.DAC1_DB0 = ramp_q[0];
  assign pins.DAC1_DB1 = ramp_q[1];
  assign pins.DAC1_DB2 = ramp_q[2];
  assign pins.DAC1_DB3 = ramp_q[3];
  assign pins.DAC1_DB4 = ramp_q[4];
  assign pins.DAC1_DB5 = ramp_q[5];
  assign pins.DAC1_DB6 = ramp_q[6];
  assign pins.DAC1_DB7 = ramp_q[7];

  assign pins.DAC2_CLK = dac_clk_q;
  assign pins.DAC2_DB0 = dac2_q[0];
  assign pins.DAC2_DB1 = dac2_q[1];
  assign pins.DAC2_DB2 = dac2_q[2];
  assign pins.DAC2_DB3 = dac2_q[3];
  assign pins.DAC2_DB4 = dac2_q[4];
  assign pins.DAC2_DB5 = dac2_q[5];
  assign pins.DAC2_DB6 = dac2_q[6];
  assign pins.DAC2_DB7 = dac2_q[7];

endmodule

// File: tb/tb_astra.sv
// Randomised self-checking bench for astra: UART command driver, TX frame monitor and a
// behavioural register/DAC model derived from the command rules.
module tb_astra;
  localparam int unsigned B  = 20;
  localparam int unsigned D  = 16;
  localparam int unsigned TB_TIMEOUT_BITS = 20;

  logic clk80 = 1'b0;
  logic rst_n;

  astra_if pins ();

  astra #(
    .BAUD_DIV    (B),
    .DAC_DIV     (D),
    .TIMEOUT_BITS(TB_TIMEOUT_BITS)
  ) dut (
    .clk80(clk80),
    .rst_n(rst_n),
    .pins (pins)
  );

  always #6 clk80 = ~clk80;

  logic [7:0] dac1, dac2;
  logic [2:0] ctrl;
  assign dac1 = {pins.DAC1_DB7, pins.DAC1_DB6, pins.DAC1_DB5, pins.DAC1_DB4,
                 pins.DAC1_DB3, pins.DAC1_DB2, pins.DAC1_DB1, pins.DAC1_DB0};
  assign dac2 = {pins.DAC2_DB7, pins.DAC2_DB6, pins.DAC2_DB5, pins.DAC2_DB4,
                 pins.DAC2_DB3, pins.DAC2_DB2, pins.DAC2_DB1, pins.DAC2_DB0};
  assign ctrl = {pins.SKUT_VI, pins.SKUT_MBR, pins.DAC_MODE};

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model state
  logic [7:0] m_step, m_level;
  logic [2:0] m_ctrl;
  logic [7:0] ack_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_dac2(input logic [7:0] d1, input logic [7:0] lvl);
`ifdef ASTRA_DAC2_MIRROR_EN
    return 8'hFF - d1;
`else
    return lvl;
`endif
  endfunction

  task automatic mon_wait(input int n, inout logic ok);
    for (int k = 0; k < n; k++) begin
      @(negedge clk80);
      if (rst_n !== 1'b1) ok = 1'b0;
    end
  endtask

  // TX monitor: decode frames at bit centres, check driver-enable framing, queue bytes.
  initial begin : tx_mon
    logic       prev_tx, prev_den, ok, stop_bit, den_a, den_b;
    logic [7:0] data;
    prev_tx  = 1'b1;
    prev_den = 1'b0;
    data     = 8'h00;
    forever begin
      @(negedge clk80);
      if (rst_n === 1'b1 && prev_tx && !pins.UART0_TX) begin
        ok = 1'b1;
        check_eq("dtx_lead", 32'(prev_den), 32'd1);
        mon_wait(B / 2, ok);
        for (int i = 0; i < 8; i++) begin
          mon_wait(B, ok);
          data[i] = pins.UART0_TX;
        end
        mon_wait(B, ok);
        stop_bit = pins.UART0_TX;
        mon_wait(B / 2, ok);
        den_a = pins.UART0_dTX & pins.UART0_dRX;
        mon_wait(1, ok);
        den_b = pins.UART0_dTX | pins.UART0_dRX;
        if (ok) begin
          check_eq("tx_stop", 32'(stop_bit), 32'd1);
          check_eq("dtx_trail", 32'(den_a), 32'd1);
          check_eq("dtx_fall", 32'(den_b), 32'd0);
          ack_q.push_back(data);
        end
      end
      prev_tx  = pins.UART0_TX;
      prev_den = pins.UART0_dTX;
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk80);
    pins.UART0_RX = 1'b0;
    repeat (B) @(negedge clk80);
    for (int i = 0; i < 8; i++) begin
      pins.UART0_RX = b[i];
      repeat (B) @(negedge clk80);
    end
    pins.UART0_RX = stop;
    repeat (B) @(negedge clk80);
    pins.UART0_RX = 1'b1;
    repeat (B) @(negedge clk80);
  endtask

  task automatic send_glitch();
    @(negedge clk80);
    pins.UART0_RX = 1'b0;
    repeat (3) @(negedge clk80);
    pins.UART0_RX = 1'b1;
    repeat (B) @(negedge clk80);
  endtask

  task automatic wait_dac_rise(output logic ok);
    logic prev;
    ok   = 1'b0;
    prev = pins.DAC1_CLK;
    for (int k = 0; k < 4 * D && !ok; k++) begin
      @(negedge clk80);
      if (!prev && pins.DAC1_CLK) ok = 1'b1;
      prev = pins.DAC1_CLK;
    end
  endtask

  task automatic check_dac();
    logic       ok;
    logic [7:0] a, b;
    wait_dac_rise(ok);
    check_eq("dac_clk_rise", 32'(ok), 32'd1);
    a = dac1;
    wait_dac_rise(ok);
    check_eq("dac_clk_rise", 32'(ok), 32'd1);
    b = dac1;
    check_eq("dac1_step", 32'(8'(b - a)), 32'(m_step));
    check_eq("dac2_level", 32'(dac2), 32'(exp_dac2(b, m_level)));
    check_eq("dac2_clk", 32'(pins.DAC2_CLK), 32'd1);
    check_eq("ctrl_lines", 32'(ctrl), 32'(m_ctrl));
  endtask

  task automatic do_cmd(input logic [7:0] addr, input logic [7:0] val);
    logic [7:0] exp_ack;
    check_eq("no_stray_ack", ack_q.size(), 32'd0);
    ack_q.delete();
    send_frame(addr, 1'b1);
    send_frame(val, 1'b1);
    exp_ack = 8'hFF;
    case (addr)
      8'h01: begin m_step  = val;      exp_ack = val; end
      8'h02: begin m_level = val;      exp_ack = val; end
      8'h03: begin m_ctrl  = val[2:0]; exp_ack = val; end
      default: ;
    endcase
    for (int k = 0; k < 14 * B && ack_q.size() == 0; k++) @(negedge clk80);
    check_eq("ack_seen", 32'(ack_q.size() != 0), 32'd1);
    if (ack_q.size() != 0) check_eq("ack_byte", 32'(ack_q.pop_front()), 32'(exp_ack));
    check_dac();
  endtask

  function automatic logic [7:0] rand_addr();
    unsigned_pick: case ($urandom_range(0, 4))
      0:       return 8'h01;
      1:       return 8'h02;
      2:       return 8'h03;
      3:       return 8'h00;
      default: return 8'($urandom_range(4, 255));
    endcase
  endfunction

  initial begin : watchdog
    #(12 * 90000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [7:0] e1;
    pins.UART0_RX = 1'b1;
    rst_n         = 1'b0;
    m_step  = 8'h01;
    m_level = 8'h80;
    m_ctrl  = 3'b000;
    repeat (3) @(negedge clk80);

    check_eq("rst_dac1", 32'(dac1), 32'h00);
    check_eq("rst_dac2", 32'(dac2), 32'h00);
    check_eq("rst_dac_clks", 32'({pins.DAC1_CLK, pins.DAC2_CLK}), 32'd0);
    check_eq("rst_ctrl", 32'(ctrl), 32'd0);
    check_eq("rst_tx", 32'(pins.UART0_TX), 32'd1);
    check_eq("rst_dtx_drx", 32'({pins.UART0_dTX, pins.UART0_dRX}), 32'd0);

    // Free-running ramp from reset: after n clock edges DAC1 = ceil(n/16) mod 256.
    rst_n = 1'b1;
    for (int n = 0; n < 16 * 260; n++) begin
      e1 = 8'(((n + 15) / 16) % 256);
      if (n < 48) begin
        check_eq("dac1_clk_phase", 32'(pins.DAC1_CLK), 32'((n % 16) >= 8));
        check_eq("dac2_clk_phase", 32'(pins.DAC2_CLK), 32'((n % 16) >= 8));
      end
      if (n < 48 || (n % 16) == 4) begin
        check_eq("ramp_dac1", 32'(dac1), 32'(e1));
        check_eq("ramp_dac2", 32'(dac2), 32'((n == 0) ? 8'h00 : exp_dac2(e1, 8'h80)));
      end
      if ((n % 512) == 100) begin
        check_eq("idle_tx", 32'({pins.UART0_TX, pins.UART0_dTX}), 32'b10);
        check_eq("idle_ctrl", 32'(ctrl), 32'd0);
      end
      @(negedge clk80);
    end

    do_cmd(8'h01, 8'h05);
    do_cmd(8'h03, 8'h07);
    do_cmd(8'h02, 8'h3C);
    do_cmd(8'h09, 8'h11);

    // Address followed by silence longer than the timeout is discarded.
    send_frame(8'h01, 1'b1);
    repeat (24 * B) @(negedge clk80);
    do_cmd(8'h02, 8'h10);

    // Framing error on the address byte resets the parser.
    send_frame(8'hA5, 1'b0);
    repeat (B) @(negedge clk80);
    do_cmd(8'h02, 8'h20);

    for (int it = 0; it < 16; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          send_frame(rand_addr(), 1'b1);
          repeat (24 * B) @(negedge clk80);
        end
        1: begin
          send_frame(8'($urandom), 1'b0);
          repeat (B) @(negedge clk80);
        end
        2: send_glitch();
        default: ;
      endcase
      do_cmd(rand_addr(), 8'($urandom));
    end

    // Reset in the middle of an ack transmission.
    check_eq("no_stray_ack", ack_q.size(), 32'd0);
    send_frame(8'h01, 1'b1);
    send_frame(8'h05, 1'b1);
    for (int k = 0; k < 4 * B && !pins.UART0_dTX; k++) @(negedge clk80);
    check_eq("dtx_before_reset", 32'(pins.UART0_dTX), 32'd1);
    repeat (3 * B) @(negedge clk80);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tx", 32'(pins.UART0_TX), 32'd1);
    check_eq("mid_rst_dtx_drx", 32'({pins.UART0_dTX, pins.UART0_dRX}), 32'd0);
    check_eq("mid_rst_dacs", 32'({dac1, dac2}), 32'd0);
    check_eq("mid_rst_ctrl", 32'(ctrl), 32'd0);
    m_step  = 8'h01;
    m_level = 8'h80;
    m_ctrl  = 3'b000;
    repeat (2) @(negedge clk80);
    rst_n = 1'b1;
    @(negedge clk80);
    check_eq("post_rst_dac1", 32'(dac1), 32'h01);
    check_eq("post_rst_dac2", 32'(dac2), 32'(exp_dac2(8'h01, 8'h80)));
    check_dac();
    repeat (10 * B) @(negedge clk80);
    check_eq("aborted_frame_not_acked", ack_q.size(), 32'd0);
    do_cmd(8'h02, 8'h5A);
    do_cmd(8'h01, 8'h03);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
